// File: rtl/multicycle_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared encodings for the multicycle RISC-V control unit: FSM state enum,
// ALU operation codes, datapath mux selects, immediate formats and the RV32I
// opcodes the decoder recognises.
// No ports (package).
// -----------------------------------------------------------------------------
package control_pkg;

   // All sixteen codes are used, so the 4-bit register has no spare encodings.
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXEC_R   = 4'd6,
      ST_EXEC_I   = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_JALR1    = 4'd11,
      ST_JALR2    = 4'd12,
      ST_LUI      = 4'd13,
      ST_AUIPC    = 4'd14,
      ST_ILLEGAL  = 4'd15
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } alu_op_t;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLL   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_SLT   = 4'd8;
   localparam logic [3:0] ALU_SLTU  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [1:0] RES_ALUOUT    = 2'd0;
   localparam logic [1:0] RES_DATA      = 2'd1;
   localparam logic [1:0] RES_ALURESULT = 2'd2;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_A     = 2'd2;

   localparam logic [1:0] SRCB_B    = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   function automatic logic branch_supported(input logic [2:0] funct3);
      return (funct3 == F3_BEQ) || (funct3 == F3_BNE);
   endfunction

   // PC update decision for the supported branches; Zero comes straight from
   // the ALU in the same cycle.
   function automatic logic branch_pc_write(input logic [2:0] funct3, input logic zero);
      return ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
// Control bundle between the multicycle control unit and its datapath.
//   Op, Funct3, Funct7, Zero       datapath -> control (instruction fields, ALU zero)
//   PCWrite, RegWrite, MemWrite,
//   IRWrite, ADRSrc, ResultSrc,
//   ALUSrcA, ALUSrcB, ALUControl,
//   ImmSrc, Illegal_o              control -> datapath
// Modports: master = control unit, slave = datapath.
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if;

   logic [6:0] Op;
   logic [2:0] Funct3;
   logic [6:0] Funct7;
   logic       Zero;

   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       IRWrite;
   logic       ADRSrc;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUControl;
   logic [2:0] ImmSrc;
   logic       Illegal_o;

   modport master (
      input  Op, Funct3, Funct7, Zero,
      output PCWrite, RegWrite, MemWrite, IRWrite, ADRSrc, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal_o
   );

   modport slave (
      output Op, Funct3, Funct7, Zero,
      input  PCWrite, RegWrite, MemWrite, IRWrite, ADRSrc, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal_o
   );

endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode.
//   alu_op       in  2  ADD / SUB / funct-decoded
//   funct3       in  3  Instr[14:12]
//   funct7_b5    in  1  Instr[30]
//   op_b5        in  1  Instr[5], 1 for R-type, 0 for I-type ALU
//   alu_control  out 4  ALU operation code
// -----------------------------------------------------------------------------
module alu_decoder
   import control_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   input  logic       op_b5,
   output logic [3:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type uses bit 30 for SUB; ADDI immediates may have it set.
               3'b000:  alu_control = (op_b5 && funct7_b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Control FSM for the multicycle RV32I datapath. Outputs are decoded from the
// state register; PCWrite in BRANCH additionally follows Zero combinationally.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-low reset; forces every output to 0
//   bus    master modport of multicycle_control_unit_if
// Parameter ILLEGAL_TRAP: 1 = unknown opcode parks in ILLEGAL, 0 = NOP.
//
// state       | meaning
// ------------+---------------------------------------------------------
// FETCH       | IR <= mem[PC], PC <= PC+4
// DECODE      | read regs, ALUOut <= OldPC+imm (branch/jal target)
// MEMADR      | ALUOut <= A+imm, load/store address
// MEMREAD     | Data <= mem[ALUOut]
// MEMWB       | rd <= Data
// MEMWRITE    | mem[ALUOut] <= B
// EXEC_R      | ALUOut <= A op B
// EXEC_I      | ALUOut <= A op imm
// ALUWB       | rd <= ALUOut
// BRANCH      | compare A-B, PC <= ALUOut when taken
// JAL         | PC <= target, ALUOut <= OldPC+4
// JALR1       | ALUOut <= A+imm
// JALR2       | PC <= ALUOut, ALUOut <= OldPC+4
// LUI         | ALUOut <= imm
// AUIPC       | ALUOut <= OldPC+imm
// ILLEGAL     | halted until reset
// -----------------------------------------------------------------------------
module multicycle_control_unit
   import control_pkg::*;
#(
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input logic clk,
   input logic reset,
   multicycle_control_unit_if.master bus
);

   state_t     state;
   state_t     state_next;
   alu_op_t    alu_op;
   logic [3:0] alu_dec;
   logic       pass_b;

   logic       pc_write;
   logic       reg_write;
   logic       mem_write;
   logic       ir_write;
   logic       adr_src;
   logic       illegal;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] imm_src;
   logic [3:0] alu_control;
   logic       funct7_unused;

   assign funct7_unused = ^{bus.Funct7[6], bus.Funct7[4:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH: state_next = ST_DECODE;
         ST_DECODE: begin
            case (bus.Op)
               OP_LOAD, OP_STORE: state_next = ST_MEMADR;
               OP_RTYPE:          state_next = ST_EXEC_R;
               OP_ITYPE:          state_next = ST_EXEC_I;
               OP_BRANCH:         state_next = ST_BRANCH;
               OP_JAL:            state_next = ST_JAL;
               OP_JALR:           state_next = ST_JALR1;
               OP_LUI:            state_next = ST_LUI;
               OP_AUIPC:          state_next = ST_AUIPC;
               default:           state_next = ILLEGAL_TRAP ? ST_ILLEGAL : ST_FETCH;
            endcase
         end
         ST_MEMADR:   state_next = (bus.Op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
         ST_MEMREAD:  state_next = ST_MEMWB;
         ST_MEMWB:    state_next = ST_FETCH;
         ST_MEMWRITE: state_next = ST_FETCH;
         ST_EXEC_R:   state_next = ST_ALUWB;
         ST_EXEC_I:   state_next = ST_ALUWB;
         ST_ALUWB:    state_next = ST_FETCH;
         ST_BRANCH:   state_next = branch_supported(bus.Funct3) ? ST_FETCH : ST_ILLEGAL;
         ST_JAL:      state_next = ST_ALUWB;
         ST_JALR1:    state_next = ST_JALR2;
         ST_JALR2:    state_next = ST_ALUWB;
         ST_LUI:      state_next = ST_ALUWB;
         ST_AUIPC:    state_next = ST_ALUWB;
         ST_ILLEGAL:  state_next = ST_ILLEGAL;
         default:     state_next = ST_FETCH;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      illegal    = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_B;
      imm_src    = IMM_I;
      alu_op     = ALUOP_ADD;
      pass_b     = 1'b0;
      case (state)
         ST_FETCH: begin
            ir_write   = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            pc_write   = 1'b1;
         end
         ST_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            if (bus.Op == OP_BRANCH) begin
               imm_src = IMM_B;
            end else if (bus.Op == OP_JAL) begin
               imm_src = IMM_J;
            end
         end
         ST_MEMADR: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
            if (bus.Op == OP_STORE) begin
               imm_src = IMM_S;
            end
         end
         ST_MEMREAD: begin
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
         end
         ST_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         ST_MEMWRITE: begin
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            mem_write  = 1'b1;
         end
         ST_EXEC_R: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_B;
            alu_op    = ALUOP_FUNCT;
         end
         ST_EXEC_I: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         ST_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_B;
            alu_op    = ALUOP_SUB;
            pc_write  = branch_pc_write(bus.Funct3, bus.Zero);
         end
         ST_JAL, ST_JALR2: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
         end
         ST_JALR1: begin
            alu_src_a = SRCA_A;
            alu_src_b = SRCB_IMM;
         end
         ST_LUI: begin
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_U;
            pass_b    = 1'b1;
         end
         ST_AUIPC: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_U;
         end
         ST_ILLEGAL: begin
            illegal = 1'b1;
         end
         default: begin
            illegal = 1'b0;
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (bus.Funct3),
      .funct7_b5   (bus.Funct7[5]),
      .op_b5       (bus.Op[5]),
      .alu_control (alu_dec)
   );

   assign alu_control = pass_b ? ALU_PASSB : alu_dec;

   // Outputs are gated by reset itself so nothing is enabled while reset is
   // low, even though the state register already reads FETCH.
   assign bus.PCWrite    = reset & pc_write;
   assign bus.RegWrite   = reset & reg_write;
   assign bus.MemWrite   = reset & mem_write;
   assign bus.IRWrite    = reset & ir_write;
   assign bus.ADRSrc     = reset & adr_src;
   assign bus.Illegal_o  = reset & illegal;
   assign bus.ResultSrc  = reset ? result_src  : 2'd0;
   assign bus.ALUSrcA    = reset ? alu_src_a   : 2'd0;
   assign bus.ALUSrcB    = reset ? alu_src_b   : 2'd0;
   assign bus.ImmSrc     = reset ? imm_src     : 3'd0;
   assign bus.ALUControl = reset ? alu_control : 4'd0;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore/Mealy control FSM that drives the multicycle RISC-V datapath. It is the other end of the datapath's control interface: it consumes `Op`, `Funct3`, `Funct7` and `Zero`, and produces every mux select and write enable the datapath needs. It sequences fetch, decode, execute, memory and writeback for RV32I base integer instructions. Unsupported encodings park the FSM in a trap state.

## Interface
Parameters:
- `ILLEGAL_TRAP`, default 1, meaning: 1 = an unknown opcode halts in ILLEGAL; 0 = treat it as a NOP and return to FETCH.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Op`  in  7  `Instr[6:0]`
- `Funct3`  in  3  `Instr[14:12]`
- `Funct7`  in  7  `Instr[31:25]`
- `Zero`  in  1  ALUResult == 0 (combinational, current cycle)
- `PCWrite`, `RegWrite`, `MemWrite`, `IRWrite`, `ADRSrc`  out  1 each
- `ResultSrc`  out  2  0 = ALUOut, 1 = Data, 2 = ALUResult
- `ALUSrcA`  out  2  0 = PC, 1 = OldPC, 2 = A
- `ALUSrcB`  out  2  0 = B, 1 = ImmExt, 2 = constant 4
- `ALUControl`  out  4  ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10
- `ImmSrc`  out  3  I 0, S 1, B 2, J 3, U 4
- `Illegal_o`  out  1  high while in the ILLEGAL state

## Operation
- Output style: all outputs decode combinationally from the state register. The one exception is `PCWrite` in BRANCH, which is Mealy on `Zero`.
- Default values: any output not listed for a state is 0.
- FETCH: ADRSrc=0, IRWrite=1, SrcA=PC, SrcB=4, ADD, ResultSrc=2, PCWrite=1. Next state: DECODE.
- DECODE: SrcA=OldPC, SrcB=Imm, ADD, so ALUOut becomes the branch/jal target.
  - ImmSrc is B for a branch opcode and J for JAL; otherwise I.
  - Next state by Op:
    - 0000011 (load) / 0100011 (store): MEMADR
    - 0110011: EXEC_R
    - 0010011: EXEC_I
    - 1100011: BRANCH
    - 1101111: JAL
    - 1100111: JALR1
    - 0110111: LUI
    - 0010111: AUIPC
    - anything else: ILLEGAL, or FETCH when ILLEGAL_TRAP=0
- MEMADR: SrcA=A, SrcB=Imm, ADD. ImmSrc is S for a store, I for a load. Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: ADRSrc=1, ResultSrc=0. Next: MEMWB.
- MEMWB: ResultSrc=1, RegWrite=1. Next: FETCH.
- MEMWRITE: ADRSrc=1, ResultSrc=0, MemWrite=1. Next: FETCH.
- EXEC_R: SrcA=A, SrcB=B, ALUControl from `alu_decoder`. Next: ALUWB.
- EXEC_I: SrcA=A, SrcB=Imm, ImmSrc=I, ALUControl from `alu_decoder`. `Funct7[5]` is honoured only when Funct3=101 (SRAI). Next: ALUWB.
- ALUWB: ResultSrc=0, RegWrite=1. Next: FETCH.
- BRANCH: SrcA=A, SrcB=B, SUB, ResultSrc=0.
  - PCWrite = Zero when Funct3=000 (BEQ); PCWrite = !Zero when Funct3=001 (BNE).
  - Any other Funct3 goes to ILLEGAL.
  - Next: FETCH.
- JAL: SrcA=OldPC, SrcB=4, ADD, ResultSrc=0, PCWrite=1. Next: ALUWB, which writes the link address OldPC+4.
- JALR1: SrcA=A, SrcB=Imm, ImmSrc=I, ADD. Next: JALR2.
- JALR2: SrcA=OldPC, SrcB=4, ADD, ResultSrc=0, PCWrite=1. Next: ALUWB.
- LUI: SrcB=Imm, ImmSrc=U, PASSB. Next: ALUWB.
- AUIPC: SrcA=OldPC, SrcB=Imm, ImmSrc=U, ADD. Next: ALUWB.
- ILLEGAL: all enables 0, `Illegal_o`=1. The FSM stays here until reset.

## Timing
- Reset: while `reset`=0, state=FETCH and every output is forced to 0. The first fetch occurs on the first rising edge after deassertion.
- Reset mid-instruction: the state is aborted immediately (asynchronous). No partial RegWrite or MemWrite survives the reset edge.
- Cycle counts per instruction:
  - load 5
  - store 4
  - R-type and I-type ALU 4
  - branch 3
  - JAL 4
  - JALR 5
  - LUI and AUIPC 4
- Taken and not-taken branches cost the same.
- `Zero` is sampled combinationally in BRANCH. It must settle within the same cycle; the PC updates on the closing edge.
- `IRWrite` is asserted only in FETCH, so `Op`, `Funct3` and `Funct7` are stable from DECODE onward.

## Structure
- Package `control_pkg` holds:
  - the state enum (4-bit)
  - the ALUControl codes
  - the ResultSrc, ALUSrcA, ALUSrcB and ImmSrc select constants
  - the opcode constants
- Sub-module `alu_decoder`: combinational. Inputs are an `ALUOp` class (0 = add, 1 = sub, 2 = funct-decoded), Funct3, Funct7[5] and Op[5]; output is ALUControl.
  - For R-type, `Funct7[5]` selects SUB versus ADD.
  - For I-type, ADDI never decodes as SUB.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset and fetch: hold reset low for 3 cycles, then release. All outputs are 0 during reset; the first cycle after release shows IRWrite=1, PCWrite=1, ALUSrcB=2; the second shows DECODE.
- Load: Op=0000011 drives the state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. ResultSrc=1 and RegWrite=1 occur in cycle 5 only.
- BEQ: Op=1100011 with Funct3=000.
  - Zero=1 gives PCWrite=1 with ResultSrc=0 in cycle 3.
  - Zero=0 gives PCWrite=0.
  - BNE (Funct3=001) gives the inverse.
- R-type SUB versus ADDI:
  - Op=0110011, Funct7=0100000, Funct3=000 gives ALUControl=1.
  - Op=0010011, Funct7=0100000, Funct3=000 gives ALUControl=0.
- JALR: 5 cycles. PCWrite=1 in JALR2 with ALUSrcA=1; RegWrite=1 in ALUWB.
- Illegal: Op=1111111 with ILLEGAL_TRAP=1 gives Illegal_o=1 from cycle 3 with all enables 0 for 10 cycles; a reset pulse then recovers to FETCH.
